// File: rtl/gpr_wb_ctrl_if.sv
// Result-producer write-request bus: one valid/ready/rd/data lane per requester.
// The controller takes the slave side; producers (or a bench) take the master side.
interface gpr_wb_ctrl_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [5*NREQ-1:0]  req_rd;
  logic [32*NREQ-1:0] req_data;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/gpr_wb_ctrl.sv
// Register-file write-back arbiter (ALU fixed priority, others round-robin)
// with a pending-write scoreboard for issue-stage operand stalls.
module gpr_wb_ctrl #(
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  gpr_wb_ctrl_if.slave       bus,
  output logic               wb_we,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  input  logic               sb_set,
  input  logic [4:0]         sb_set_rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic               idle
);

  localparam int NU  = NREQ - 1;
  localparam int RRW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [RRW-1:0]  rr_reg, rr_next;
  logic [31:0]     busy_reg, busy_next;
  logic            wb_we_reg;
  logic [4:0]      wb_rd_reg;
  logic [31:0]     wb_data_reg;

  logic [NREQ-1:0] grant;
  logic            found;
  int              idx;
  logic [4:0]      sel_rd;
  logic [31:0]     sel_data;

  logic [4:0]      rd_arr   [NREQ];
  logic [31:0]     data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
    assign rd_arr[gi]   = bus.req_rd[5*gi +: 5];
    assign data_arr[gi] = bus.req_data[32*gi +: 32];
  end

  // Search order for the multi-cycle units is rr, rr+1, ... wrapping NU -> 1.
  always_comb begin
    grant   = '0;
    rr_next = rr_reg;
    found   = 1'b0;
    idx     = 0;
    if (bus.req_valid[0]) begin
      grant[0] = 1'b1;
    end else begin
      for (int off = 0; off < NU; off++) begin
        idx = int'(rr_reg) + off;
        if (idx > NU) idx = idx - NU;
        if (!found && bus.req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          rr_next    = (idx == NU) ? RRW'(1) : RRW'(idx + 1);
        end
      end
    end
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = rd_arr[i];
        sel_data = data_arr[i];
      end
    end
  end

  // Set is applied after clear so a same-edge re-dispatch keeps the bit.
  always_comb begin
    busy_next = busy_reg;
    if (wb_we_reg) busy_next[wb_rd_reg] = 1'b0;
    if (sb_set && (sb_set_rd != 5'd0)) busy_next[sb_set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_reg      <= RRW'(1);
      busy_reg    <= '0;
      wb_we_reg   <= 1'b0;
      wb_rd_reg   <= '0;
      wb_data_reg <= '0;
    end else begin
      rr_reg    <= rr_next;
      busy_reg  <= busy_next;
      wb_we_reg <= (|grant) && (sel_rd != 5'd0);
      if (|grant) begin
        wb_rd_reg   <= sel_rd;
        wb_data_reg <= sel_data;
      end
    end
  end

  assign bus.req_ready = rst ? grant : '0;

  assign wb_we   = wb_we_reg;
  assign wb_rd   = wb_rd_reg;
  assign wb_data = wb_data_reg;

  // The register file forwards the in-flight write, so that cycle need not stall.
  assign rs1_busy = busy_reg[rs1] && !(wb_we_reg && (wb_rd_reg == rs1));
  assign rs2_busy = busy_reg[rs2] && !(wb_we_reg && (wb_rd_reg == rs2));
  assign idle     = (busy_reg == 32'd0) && !wb_we_reg;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: tasks drive scenarios and push expected write-port
// values into a queue that a negedge monitor pops and compares.
module tb_gpr_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        sb_set;
  logic [4:0]  sb_set_rd;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy, idle;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  logic [4:0]  cur_rd [3];
  logic [31:0] cur_d  [3];

  gpr_wb_ctrl_if #(.NREQ(3)) bus ();

  gpr_wb_ctrl #(.NREQ(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .sb_set    (sb_set),
    .sb_set_rd (sb_set_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks = checks + 1;
      if (e.due != cyc || wb_we !== e.we ||
          (e.we && (wb_rd !== e.rd || wb_data !== e.data))) begin
        errors = errors + 1;
        $display("FAIL wb_port cyc=%0d due=%0d got we=%0b rd=%0d data=%h exp we=%0b rd=%0d data=%h",
                 cyc, e.due, wb_we, wb_rd, wb_data, e.we, e.rd, e.data);
      end else begin
        $display("wb cyc=%0d we=%0b rd=%0d data=%h", cyc, wb_we, wb_rd, wb_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.due  = cyc + 1;
    e.we   = we;
    e.rd   = rd;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      bus.req_rd[5*i +: 5]    = cur_rd[i];
      bus.req_data[32*i +: 32] = cur_d[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = 3'b111;
    cur_rd[0] = 5'd1; cur_rd[1] = 5'd2; cur_rd[2] = 5'd3;
    cur_d[0] = 32'h1; cur_d[1] = 32'h2; cur_d[2] = 32'h3;
    apply();
    repeat (2) @(posedge clk);
    #3;
    checks = checks + 1;
    if (bus.req_ready !== 3'b000 || wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || idle !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL reset_state got ready=%b we=%b rd=%0d data=%h idle=%b exp 000 0 0 0 1",
               bus.req_ready, wb_we, wb_rd, wb_data, idle);
    end
    step();
    bus.req_valid = 3'b000;
    rst = 1'b1;
    #2;
    checks = checks + 1;
    if (idle !== 1'b1 || rs1_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_release got idle=%b rs1_busy=%b exp 1 0", idle, rs1_busy);
    end
    step();
  endtask

  task automatic test_single();
    cur_rd[1] = 5'd5; cur_d[1] = 32'hDEADBEEF;
    apply();
    bus.req_valid = 3'b010;
    #2;
    checks = checks + 1;
    if (bus.req_ready !== 3'b010) begin
      errors = errors + 1;
      $display("FAIL single_ready got=%b exp=010", bus.req_ready);
    end
    push(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    bus.req_valid = 3'b000;
    push(1'b0, 5'd0, 32'd0);
    step();
    step();
    checks = checks + 1;
    if (idle !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL single_idle got=%b exp=1", idle);
    end
  endtask

  task automatic test_rd0_discard();
    cur_rd[2] = 5'd0; cur_d[2] = 32'h1234;
    apply();
    bus.req_valid = 3'b100;
    #2;
    checks = checks + 1;
    if (bus.req_ready !== 3'b100) begin
      errors = errors + 1;
      $display("FAIL rd0_ready got=%b exp=100", bus.req_ready);
    end
    push(1'b0, 5'd0, 32'd0);
    step();
    // pointer must be back at 1, so requester 1 wins over 2
    cur_rd[1] = 5'd4; cur_d[1] = 32'h0000_4444;
    cur_rd[2] = 5'd6; cur_d[2] = 32'h0000_6666;
    apply();
    bus.req_valid = 3'b110;
    #2;
    checks = checks + 1;
    if (bus.req_ready !== 3'b010) begin
      errors = errors + 1;
      $display("FAIL rd0_rr_wrap got=%b exp=010", bus.req_ready);
    end
    push(1'b1, 5'd4, 32'h0000_4444);
    step();
    bus.req_valid = 3'b000;
    push(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_priority_rr();
    int seq [4];
    logic [2:0] exp_rdy;
    seq[0] = 2; seq[1] = 1; seq[2] = 2; seq[3] = 1;
    cur_rd[0] = 5'd1; cur_rd[1] = 5'd2; cur_rd[2] = 5'd3;
    cur_d[1] = 32'hB100_0000; cur_d[2] = 32'hC200_0000;
    bus.req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cur_d[0] = 32'hA000_0000 + k;
      apply();
      #2;
      checks = checks + 1;
      if (bus.req_ready !== 3'b001) begin
        errors = errors + 1;
        $display("FAIL alu_prio k=%0d got=%b exp=001", k, bus.req_ready);
      end
      push(1'b1, 5'd1, 32'hA000_0000 + k);
      step();
    end
    bus.req_valid = 3'b110;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = 3'b000;
      exp_rdy[seq[k]] = 1'b1;
      #2;
      checks = checks + 1;
      if (bus.req_ready !== exp_rdy) begin
        errors = errors + 1;
        $display("FAIL rr_order k=%0d got=%b exp=%b", k, bus.req_ready, exp_rdy);
      end
      push(1'b1, cur_rd[seq[k]], cur_d[seq[k]]);
      step();
      cur_d[seq[k]] = cur_d[seq[k]] + 1;
      apply();
    end
    bus.req_valid = 3'b000;
    #2;
    checks = checks + 1;
    if (bus.req_ready !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL rr_release got=%b exp=000", bus.req_ready);
    end
    push(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_scoreboard();
    rs1 = 5'd7; rs2 = 5'd7;
    sb_set = 1'b1; sb_set_rd = 5'd7;
    #2;
    checks = checks + 1;
    if (rs1_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL sb_before_set got=%b exp=0", rs1_busy);
    end
    step();
    sb_set = 1'b0;
    #2;
    checks = checks + 1;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1 || idle !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL sb_set got rs1=%b rs2=%b idle=%b exp 1 1 0", rs1_busy, rs2_busy, idle);
    end
    cur_rd[1] = 5'd7; cur_d[1] = 32'h0000_0077;
    apply();
    bus.req_valid = 3'b010;
    push(1'b1, 5'd7, 32'h0000_0077);
    step();
    bus.req_valid = 3'b000;
    #2;
    checks = checks + 1;
    if (rs1_busy !== 1'b0 || idle !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL sb_bypass got rs1=%b idle=%b exp 0 0", rs1_busy, idle);
    end
    push(1'b0, 5'd0, 32'd0);
    step();
    #2;
    checks = checks + 1;
    if (rs1_busy !== 1'b0 || idle !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL sb_cleared got rs1=%b idle=%b exp 0 1", rs1_busy, idle);
    end
  endtask

  task automatic test_same_edge();
    rs1 = 5'd9;
    sb_set = 1'b1; sb_set_rd = 5'd9;
    step();
    sb_set = 1'b0;
    cur_rd[2] = 5'd9; cur_d[2] = 32'h0000_0099;
    apply();
    bus.req_valid = 3'b100;
    push(1'b1, 5'd9, 32'h0000_0099);
    step();
    bus.req_valid = 3'b000;
    sb_set = 1'b1; sb_set_rd = 5'd9;
    push(1'b0, 5'd0, 32'd0);
    step();
    sb_set = 1'b0;
    #2;
    checks = checks + 1;
    if (rs1_busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL same_edge_set_wins got=%b exp=1", rs1_busy);
    end
    cur_rd[1] = 5'd9; cur_d[1] = 32'h0000_0999;
    apply();
    bus.req_valid = 3'b010;
    push(1'b1, 5'd9, 32'h0000_0999);
    step();
    bus.req_valid = 3'b000;
    step();
    sb_set = 1'b1; sb_set_rd = 5'd0;
    step();
    sb_set = 1'b0;
    rs1 = 5'd0;
    #2;
    checks = checks + 1;
    if (idle !== 1'b1 || rs1_busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL sb_rd0 got idle=%b rs1=%b exp 1 0", idle, rs1_busy);
    end
  endtask

  task automatic test_async_reset();
    sb_set = 1'b1; sb_set_rd = 5'd3;
    step();
    sb_set_rd = 5'd12;
    cur_rd[1] = 5'd20; cur_d[1] = 32'h2020_2020;
    apply();
    bus.req_valid = 3'b010;
    step();
    sb_set = 1'b0;
    bus.req_valid = 3'b110;
    rs1 = 5'd3; rs2 = 5'd12;
    #1;
    checks = checks + 1;
    if (wb_we !== 1'b1 || wb_rd !== 5'd20 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL pre_reset got we=%b rd=%0d rs1=%b rs2=%b exp 1 20 1 1", wb_we, wb_rd, rs1_busy, rs2_busy);
    end
    #1;
    rst = 1'b0;
    #1;
    checks = checks + 1;
    if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || idle !== 1'b1 ||
        rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || bus.req_ready !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL async_reset got we=%b rd=%0d data=%h idle=%b rs1=%b rs2=%b ready=%b exp 0 0 0 1 0 0 000",
               wb_we, wb_rd, wb_data, idle, rs1_busy, rs2_busy, bus.req_ready);
    end
    step();
    rst = 1'b1;
    cur_d[1] = 32'h2121_2121; cur_rd[2] = 5'd22; cur_d[2] = 32'h2222_2222;
    apply();
    #2;
    checks = checks + 1;
    if (bus.req_ready !== 3'b010) begin
      errors = errors + 1;
      $display("FAIL rr_after_reset got=%b exp=010", bus.req_ready);
    end
    push(1'b1, 5'd20, 32'h2121_2121);
    step();
    bus.req_valid = 3'b000;
    push(1'b0, 5'd0, 32'd0);
    step();
  endtask

  initial begin
    sb_set = 1'b0; sb_set_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    bus.req_valid = 3'b000; bus.req_rd = '0; bus.req_data = '0;
    test_reset();
    test_single();
    test_rd0_discard();
    test_priority_rr();
    test_scoreboard();
    test_same_edge();
    test_async_reset();
    repeat (3) step();
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Write-back controller for the 32x32 two-read/one-write general purpose register file. It arbitrates the register file's single write port between several result producers (ALU, load/store unit, multiplier/divider) through valid/ready handshakes and registers the winning write onto the write port. It also keeps a pending-write scoreboard that the issue stage queries to stall on operands whose producer has not yet written back. It sits between the execute-stage result producers and the register file write port.

## Interface
- NREQ, 3: number of write requesters. Index 0 is the ALU; indices 1..NREQ-1 are multi-cycle units.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i holds a write request.
- req_ready  out  NREQ  request i is accepted this cycle (one-hot or zero).
- req_rd  in  5*NREQ  destination register of requester i (slice [5i+4:5i]).
- req_data  in  32*NREQ  write data of requester i (slice [32i+31:32i]).
- wb_we  out  1  register file write enable.
- wb_rd  out  5  register file write address.
- wb_data  out  32  register file write data.
- sb_set  in  1  issue stage dispatches an instruction to a multi-cycle unit.
- sb_set_rd  in  5  destination register of that instruction.
- rs1, rs2  in  5 each  operand register numbers to check.
- rs1_busy, rs2_busy  out  1 each  the operand has an outstanding write not yet visible at the register file.
- idle  out  1  no busy bits are set and wb_we=0.

## Operation
- Arbitration is combinational within a cycle:
  - Requester 0 has fixed highest priority. If req_valid[0]=1, then req_ready[0]=1.
  - Otherwise requesters 1..NREQ-1 are served round-robin. A pointer rr (reset value 1) marks the first requester to check. The search goes rr, rr+1, …, wrapping from NREQ-1 back to 1.
  - After a grant to requester k≥1, rr becomes k+1, wrapping to 1. A grant to requester 0 leaves rr unchanged.
- At most one req_ready bit is set per cycle. req_ready never depends on any downstream stall, because the register file always accepts a write.
- The handshake completes when req_valid[i]=1 and req_ready[i]=1 in the same cycle. A requester that is not granted holds its valid, rd and data stable until it is granted.
- Output register: the granted request is loaded into wb_rd/wb_data on the next edge.
  - wb_we = 1 only if the granted rd≠0. An rd=0 request is accepted and discarded.
  - wb_we is never asserted with wb_rd=0.
  - If nothing is granted, wb_we=0 and wb_rd/wb_data hold their previous values.
- Scoreboard: 32-bit busy vector. busy[0] is hard-wired to 0.
  - Set: busy[sb_set_rd] is set on the edge where sb_set=1 and sb_set_rd≠0.
  - Clear: busy[wb_rd] is cleared on the edge that ends a cycle with wb_we=1.
  - If a set and a clear hit the same register on the same edge, the set wins.
  - The ALU writes back in the cycle after issue, so ALU results use the register file bypass and never set busy.
- Lookup: rsX_busy = busy[rsX] && !(wb_we && wb_rd==rsX). The register file forwards the in-flight write data, so the final write-back cycle does not stall.
- Reset (rst=0, asynchronous) forces wb_we=0, wb_rd=0, wb_data=0, busy=0 and rr=1.
  - req_ready is combinational from req_valid; it stays 0 while rst=0.
  - Reset in the middle of operation drops all pending and buffered writes.

## Timing
- Request accepted in cycle N → wb_we/wb_rd/wb_data valid during cycle N+1 → register file updated at the end of N+1.
- sb_set in cycle N → rsX_busy reflects it from cycle N+1.
- Final write of register r in cycle M (wb_we=1):
  - rsX_busy for r is already 0 during M, through the bypass term.
  - busy[r] is clear from M+1 unless r was set again in M.
- Throughput is one write per cycle. Requester 0 can starve the others indefinitely; that is the intended policy.
- idle is combinational from the current state.

## Test plan
- Reset then single request: rst released; req_valid=3'b010, rd=5, data=0xDEADBEEF in cycle N → req_ready=3'b010 in N; wb_we=1, wb_rd=5, wb_data=0xDEADBEEF in N+1; wb_we=0 in N+2.
- ALU priority and round-robin: req_valid=3'b111 held with requesters 1 and 2 busy-waiting → grants go 0 while req_valid[0]=1. Drop req_valid[0] → grants alternate 1, 2, 1, 2, each for one cycle. No valid requester is ever dropped.
- rd=0 discard: requester 2 sends rd=0, data=0x1234 → req_ready[2]=1; wb_we stays 0 the next cycle; rr advances to 1.
- Scoreboard lifecycle: sb_set with rd=7 at cycle N → rs1=7 gives rs1_busy=1 from N+1. Requester 1 writes rd=7 and is accepted at cycle M → rs1_busy=0 in M+1, the wb_we cycle; busy[7] is clear afterwards; idle=1.
- Same-edge set and clear: busy[9] is set, wb_we=1 with wb_rd=9, and sb_set=1 with sb_set_rd=9 in the same cycle → busy[9] remains 1 afterwards. sb_set with rd=0 → busy unchanged.
- Asynchronous reset mid-operation: busy has bits 3 and 12 set and wb_we=1; rst pulled low between clock edges → wb_we=0, wb_rd=0, busy=0 and idle=1 immediately, without waiting for a clock edge. rr=1 after release.
